// File: rtl/seq_det_prog_if.sv
// Bus bundle for the programmable serial pattern detector.
// The slave modport is the detector side and the master modport is the driver side.
// With SEQ_DET_MASK_EN defined, the bundle also carries cfg_mask.
interface seq_det_prog_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             x;
    logic             overlap;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] cfg_mask;
`endif
    logic             cnt_clr;
    logic             detect;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;

    modport master (
        output in_valid, x, overlap, cfg_load, cfg_pattern,
`ifdef SEQ_DET_MASK_EN
        output cfg_mask,
`endif
        output cnt_clr,
        input  detect, match_cnt, armed
    );

    modport slave (
        input  in_valid, x, overlap, cfg_load, cfg_pattern,
`ifdef SEQ_DET_MASK_EN
        input  cfg_mask,
`endif
        input  cnt_clr,
        output detect, match_cnt, armed
    );
endinterface

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector.
// It matches a PAT_W-bit pattern that can be loaded at run time.
// The oldest received bit is compared against the MSB of the pattern.
// Matching can be overlapping or non-overlapping.
// The match counter saturates, and the detect output is a registered one-cycle pulse.
// Optional feature: when SEQ_DET_MASK_EN is defined, cfg_mask marks don't-care positions.
module seq_det_prog #(
    parameter int unsigned      PAT_W       = 4,
    parameter int unsigned      CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011)
) (
    input logic          clk,
    input logic          rst,
    seq_det_prog_if.slave bus
);
    localparam int unsigned      FillW    = $clog2(PAT_W + 1);
    localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    typedef enum logic [0:0] {StFill, StArmed} state_e;

    state_e           state_q;
    logic [PAT_W-1:0] pattern_q;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] mask_q;
`endif
    // Only PAT_W-1 bits are stored.
    // The compare window is these stored bits followed by the incoming bit.
    logic [PAT_W-2:0] hist_q;
    logic [FillW-1:0] fill_q;
    logic             detect_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accepted;
    logic [PAT_W-1:0] hist_d;
    logic [FillW-1:0] fill_d;
    logic [PAT_W-1:0] diff;
    logic             hit;

    // Build the next history window and evaluate the match against it.
    always_comb begin
        accepted = bus.in_valid & ~bus.cfg_load;
        hist_d   = {hist_q, bus.x};
        fill_d   = (fill_q == FillFull) ? FillFull : fill_q + 1'b1;
`ifdef SEQ_DET_MASK_EN
        diff     = (hist_d ^ pattern_q) & ~mask_q;
`else
        diff     = hist_d ^ pattern_q;
`endif
        hit      = accepted & (fill_d == FillFull) & (diff == '0);
    end

    // Sequential logic: the FILL/ARMED FSM, the history, the counter and the detect pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFill;
            pattern_q <= DEFAULT_PAT;
`ifdef SEQ_DET_MASK_EN
            mask_q    <= '0;
`endif
            hist_q    <= '0;
            fill_q    <= '0;
            detect_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            detect_q <= hit;

            if (bus.cfg_load) begin
                pattern_q <= bus.cfg_pattern;
`ifdef SEQ_DET_MASK_EN
                mask_q    <= bus.cfg_mask;
`endif
                hist_q    <= '0;
                fill_q    <= '0;
                state_q   <= StFill;
            end else if (bus.in_valid) begin
                hist_q <= hist_d[PAT_W-2:0];
                // A non-overlapping hit restarts the fill in either state.
                // Any hit is the bit that completes the window.
                if (hit && !bus.overlap) begin
                    fill_q  <= '0;
                    state_q <= StFill;
                end else begin
                    fill_q  <= fill_d;
                    state_q <= (fill_d == FillFull) ? StArmed : StFill;
                end
            end

            if (bus.cnt_clr) begin
                cnt_q <= hit ? CNT_W'(1) : '0;
            end else if (hit && (cnt_q != CntMax)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.detect    = detect_q;
    assign bus.match_cnt = cnt_q;
    assign bus.armed     = (state_q == StArmed);
endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog.
// It has two instances: u_dut0 (CNT_W=8) and u_dut1 (CNT_W=2), and both see the same stimulus.
// Stimulus vectors are listed with their expected outputs.
// The expected values are queued when a vector is driven and compared after the clock edge.
module tb_seq_det_prog;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_det_prog_if #(.PAT_W(4), .CNT_W(8)) if0 ();
    seq_det_prog_if #(.PAT_W(4), .CNT_W(2)) if1 ();

    assign if1.in_valid    = if0.in_valid;
    assign if1.x           = if0.x;
    assign if1.overlap     = if0.overlap;
    assign if1.cfg_load    = if0.cfg_load;
    assign if1.cfg_pattern = if0.cfg_pattern;
    assign if1.cnt_clr     = if0.cnt_clr;
`ifdef SEQ_DET_MASK_EN
    assign if1.cfg_mask    = if0.cfg_mask;
`endif

    seq_det_prog #(.PAT_W(4), .CNT_W(8), .DEFAULT_PAT(4'b1011)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    seq_det_prog #(.PAT_W(4), .CNT_W(2), .DEFAULT_PAT(4'b1011)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic       x;
        logic       ov;
        logic       ld;
        logic       clr;
        logic [3:0] pat;
        logic       det;
        int         cnt;
        logic       arm;
        int         cnt2;  // -1: u_dut1 count not checked
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic r, input logic v, input logic xx, input logic o,
                                input logic l, input logic c, input logic [3:0] p,
                                input logic d, input int cn, input logic a, input int c2);
        vec_t t;
        t.rst = r; t.vld = v; t.x = xx; t.ov = o; t.ld = l; t.clr = c; t.pat = p;
        t.det = d; t.cnt = cn; t.arm = a; t.cnt2 = c2;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        rst             = v.rst;
        if0.in_valid    = v.vld;
        if0.x           = v.x;
        if0.overlap     = v.ov;
        if0.cfg_load    = v.ld;
        if0.cnt_clr     = v.clr;
        if0.cfg_pattern = v.pat;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".detect"}, int'(if0.detect), int'(e.det));
            check({tag, ".match_cnt"}, int'(if0.match_cnt), e.cnt);
            check({tag, ".armed"}, int'(if0.armed), int'(e.arm));
            if (e.cnt2 >= 0) check({tag, ".cnt_w2"}, int'(if1.match_cnt), e.cnt2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hits;
        vec_t v;
        rst = 1'b1;
        if0.in_valid = 1'b0; if0.x = 1'b0; if0.overlap = 1'b1; if0.cfg_load = 1'b0;
        if0.cnt_clr = 1'b0; if0.cfg_pattern = 4'b0000;
`ifdef SEQ_DET_MASK_EN
        if0.cfg_mask = 4'b0000;
`endif
        @(posedge clk);
        #1;

        // Fields: rst vld x ov ld clr pat | det cnt arm cnt2
        // 1: overlapping 1011011
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4'h0, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 4'h0, 0, 1, 1, -1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 1, 1, -1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4'h0, 1, 2, 1, 2));
        // 2: non-overlapping 1011011
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4'h0, 1, 1, 0, -1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'h0, 0, 1, 0, -1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4'h0, 0, 1, 0, -1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4'h0, 0, 1, 0, -1));
        // 3: 101, three idle cycles, then 011
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 4'h0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 4'h0, 0, 0, 1, -1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 0, 1, -1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4'h0, 1, 1, 1, -1));
        // 4: bits 1,0 then load 0110 (same-cycle bit dropped), then 0110
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 1, 1, -1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 4'h0, 0, 1, 1, -1));
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 4'h6, 0, 1, 0, -1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 4'h0, 0, 1, 0, -1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 1, 0, -1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 1, 0, -1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 4'h0, 1, 2, 1, -1));
        // cnt_clr alone while idle; armed holds
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 4'h0, 0, 0, 1, -1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // 5: 1011 x5 overlapping; u_dut1 saturates at 3; cnt_clr on the 5th hit gives 1
        apply(mk(1, 0, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0), "t5.rst");
        for (int k = 0; k < 20; k++) begin
            hits = (k + 1) / 4;
            v = mk(0, 1, (k % 4 == 1) ? 1'b0 : 1'b1, 1, 0, (k == 19), 4'h0,
                   (k % 4 == 3), (k == 19) ? 1 : hits, (k >= 3),
                   (k == 19) ? 1 : ((hits > 3) ? 3 : hits));
            apply(v, $sformatf("t5.b%0d", k));
        end

        // 6: reset mid-stream discards the partial match
        apply(mk(1, 0, 0, 1, 0, 0, 4'h0, 0, 0, 0, -1), "t6.rst0");
        apply(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 0, 0, -1), "t6.p1");
        apply(mk(0, 1, 0, 1, 0, 0, 4'h0, 0, 0, 0, -1), "t6.p2");
        apply(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 0, 0, -1), "t6.p3");
        apply(mk(1, 1, 1, 1, 0, 0, 4'h0, 0, 0, 0, 0), "t6.rst1");
        apply(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 0, 0, -1), "t6.b1");
        apply(mk(0, 1, 0, 1, 0, 0, 4'h0, 0, 0, 0, -1), "t6.b2");
        apply(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 0, 0, -1), "t6.b3");
        apply(mk(0, 1, 1, 1, 0, 0, 4'h0, 1, 1, 1, 1), "t6.b4");

`ifdef SEQ_DET_MASK_EN
        // Mask position 2 is don't-care, so 1111 matches 1011
        if0.cfg_mask = 4'b0100;
        apply(mk(0, 0, 0, 1, 1, 0, 4'hB, 0, 1, 0, -1), "mask.ld");
        if0.cfg_mask = 4'b0000;
        apply(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 1, 0, -1), "mask.b1");
        apply(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 1, 0, -1), "mask.b2");
        apply(mk(0, 1, 1, 1, 0, 0, 4'h0, 0, 1, 0, -1), "mask.b3");
        apply(mk(0, 1, 1, 1, 0, 0, 4'h0, 1, 2, 1, -1), "mask.b4");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
